// File: rtl/wb_spi_slave.sv
// SPI responder with an 8-bit Wishbone register port. All SPI pins are oversampled
// in wb_clk_i; a small frame FSM gates the byte engine driven by detected sck edges.
module wb_spi_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter logic [7:0]  TX_IDLE     = 8'hFF
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic [2:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  output logic       wb_ack_o,
  output logic       irq_o,
  input  logic       ss_i,
  input  logic       sck_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o
);

  typedef enum logic {S_IDLE, S_FRAME} state_t;

  localparam logic [2:0] A_RXDATA = 3'd0;
  localparam logic [2:0] A_TXDATA = 3'd1;
  localparam logic [2:0] A_STATUS = 3'd2;
  localparam logic [2:0] A_CTRL   = 3'd3;

  logic [SYNC_STAGES-1:0] ss_p, sck_p, mosi_p;
  logic       ss_s, sck_s, mosi_s;
  logic       ss_d, sck_d;

  state_t     state, state_nxt;
  logic       frame_start, frame_end, in_frame;

  logic [3:0] ctrl;
  logic       en;
  logic       rxf, txe, ovr, udr;
  logic [7:0] rxdata, tx_buf;
  logic [7:0] rx_shift, tx_shift;
  logic [2:0] bit_cnt;

  logic       req, wr_tx, wr_st, wr_ctrl, rd_rx;
  logic       sck_chg, lead_edge, trail_edge, sample_edge, shift_edge;
  logic       ss_fall, ss_rise;
  logic       do_sample, do_shift, tx_load, byte_done;
  logic [7:0] rx_byte;
  logic [7:0] rd_mux;

  // ---- synchroniser stage: pins -> wb_clk_i domain
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ss_p   <= '1;
      sck_p  <= {SYNC_STAGES{CPOL}};
      mosi_p <= '0;
      ss_d   <= 1'b1;
      sck_d  <= CPOL;
    end else begin
      ss_p   <= {ss_p[SYNC_STAGES-2:0], ss_i};
      sck_p  <= {sck_p[SYNC_STAGES-2:0], sck_i};
      mosi_p <= {mosi_p[SYNC_STAGES-2:0], mosi_i};
      ss_d   <= ss_s;
      sck_d  <= sck_s;
    end
  end

  assign ss_s   = ss_p[SYNC_STAGES-1];
  assign sck_s  = sck_p[SYNC_STAGES-1];
  assign mosi_s = mosi_p[SYNC_STAGES-1];

  // ---- edge detection stage
  assign sck_chg     = sck_s ^ sck_d;
  assign lead_edge   = sck_chg & (sck_s != CPOL);
  assign trail_edge  = sck_chg & (sck_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge  : trail_edge;
  assign ss_fall     = ss_d & ~ss_s;
  assign ss_rise     = ~ss_d & ss_s;

  assign en = ctrl[0];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= S_IDLE;
    else             state <= state_nxt;
  end

  // Clearing EN is treated exactly like the host raising ss.
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ss_fall && en) begin
          state_nxt   = S_FRAME;
          frame_start = 1'b1;
        end
      end
      S_FRAME: begin
        if (ss_rise || !en) begin
          state_nxt = S_IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign in_frame  = (state == S_FRAME);
  assign do_sample = in_frame & ~frame_end & sample_edge;
  assign do_shift  = in_frame & ~frame_end & shift_edge;
  assign tx_load   = (frame_start & ~CPHA) | (do_shift & (bit_cnt == 3'd0));
  assign byte_done = do_sample & (bit_cnt == 3'd7);
  assign rx_byte   = {rx_shift[6:0], mosi_s};

  // ---- bus decode: side effects happen on the edge that raises ack
  assign req     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr_tx   = req & wb_we_i  & (wb_adr_i == A_TXDATA);
  assign wr_st   = req & wb_we_i  & (wb_adr_i == A_STATUS);
  assign wr_ctrl = req & wb_we_i  & (wb_adr_i == A_CTRL);
  assign rd_rx   = req & ~wb_we_i & (wb_adr_i == A_RXDATA);

  always_comb begin
    rd_mux = 8'h00;
    case (wb_adr_i)
      A_RXDATA: rd_mux = rxdata;
      A_STATUS: rd_mux = {3'b000, ~ss_s, udr, ovr, txe, rxf};
      A_CTRL:   rd_mux = {4'h0, ctrl};
      default:  rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'h00;
      ctrl     <= 4'h0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req && !wb_we_i) ? rd_mux : 8'h00;
      if (wr_ctrl) ctrl <= wb_dat_i[3:0];
    end
  end

  // ---- byte engine stage
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 8'h00;
      tx_shift <= 8'h00;
    end else begin
      if (frame_start || frame_end) bit_cnt <= 3'd0;
      else if (do_sample)           bit_cnt <= bit_cnt + 3'd1;
      if (do_sample) rx_shift <= rx_byte;
      // The load always sees the pre-write buffer state.
      if (tx_load)       tx_shift <= txe ? TX_IDLE : tx_buf;
      else if (do_shift) tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  // ---- buffer and flag stage
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rxf    <= 1'b0;
      txe    <= 1'b1;
      ovr    <= 1'b0;
      udr    <= 1'b0;
      rxdata <= 8'h00;
      tx_buf <= 8'h00;
    end else begin
      // A pop in the same clock as completion frees the slot for the new byte.
      if (byte_done && (!rxf || rd_rx)) rxdata <= rx_byte;
      if (byte_done)  rxf <= 1'b1;
      else if (rd_rx) rxf <= 1'b0;
      if (byte_done && rxf && !rd_rx)  ovr <= 1'b1;
      else if (wr_st && wb_dat_i[2])   ovr <= 1'b0;
      if (tx_load && txe)              udr <= 1'b1;
      else if (wr_st && wb_dat_i[3])   udr <= 1'b0;
      if (wr_tx)        txe <= 1'b0;
      else if (tx_load) txe <= 1'b1;
      if (wr_tx) tx_buf <= wb_dat_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) irq_o <= 1'b0;
    else irq_o <= (rxf & ctrl[1]) | (txe & ctrl[2]) | ((ovr | udr) & ctrl[3]);
  end

  assign miso_o    = tx_shift[7];
  assign miso_oe_o = in_frame;

endmodule
